// File: rtl/wic_ctrl_param.sv
// Parametrised wake-up interrupt controller: per-source pending capture, fixed-priority arbitration, sleep/wake FSM.
// Define WIC_INT_SYNC_EN to pass every int_vld line through a 2-flop synchroniser before capture.
module wic_ctrl_param #(
    parameter int NUM_INT  = 32,
    parameter int ID_W     = 5,
    parameter int WAKE_DLY = 4,
    parameter int CNT_W    = 8
) (
    input  logic               wic_clk,
    input  logic               pad_cpu_rst,
    input  logic [NUM_INT-1:0] int_vld,
    input  logic [NUM_INT-1:0] int_cfg,
    input  logic [NUM_INT-1:0] awake_enable,
    input  logic               ack_vld,
    input  logic [ID_W-1:0]    ack_id,
    input  logic               cpu_sleep_req,
    input  logic               cpu_wakeup_ack,
    output logic [NUM_INT-1:0] int_pending,
    output logic               intraw_vld,
    output logic               arb_vld,
    output logic [ID_W-1:0]    arb_id,
    output logic               wakeup_req,
    output logic [1:0]         wic_state
);
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_DELAY = 2'b10;
    localparam logic [1:0] ST_WAKE  = 2'b11;
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(WAKE_DLY);

    logic [NUM_INT-1:0] w_int_src;
    logic [NUM_INT-1:0] w_ack_hit;
    logic [NUM_INT-1:0] w_pend_nxt;
    logic [NUM_INT-1:0] w_enabled;
    logic [NUM_INT-1:0] r_int_prev;
    logic [NUM_INT-1:0] r_pending;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_wakeup_req;
    logic               w_arb_vld;
    logic [ID_W-1:0]    w_arb_id;

`ifdef WIC_INT_SYNC_EN
    logic [NUM_INT-1:0] r_sync_0;
    logic [NUM_INT-1:0] r_sync_1;

    always_ff @(posedge wic_clk) begin
        if (pad_cpu_rst) begin
            r_sync_0 <= '0;
            r_sync_1 <= '0;
        end else begin
            r_sync_0 <= int_vld;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_int_src = r_sync_1;
`else
    assign w_int_src = int_vld;
`endif

    // Pulse sources: a fresh rising edge beats an acknowledge arriving in the same cycle.
    always_comb begin
        w_ack_hit  = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_ack_hit[i] = ack_vld && (ack_id == ID_W'(i));
            if (!int_cfg[i]) begin
                w_pend_nxt[i] = w_int_src[i];
            end else if (w_int_src[i] && !r_int_prev[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_ack_hit[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else begin
                w_pend_nxt[i] = r_pending[i];
            end
        end
    end

    assign w_enabled = r_pending & awake_enable;

    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_id  = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_enabled[i]) begin
                w_arb_vld = 1'b1;
                w_arb_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (cpu_sleep_req) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_arb_vld) begin
                    if (WAKE_DLY == 0) begin
                        w_state_nxt = ST_WAKE;
                    end else begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = DLY_LOAD;
                    end
                end
            end
            ST_DELAY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = ST_WAKE;
            end
            default: begin
                if (cpu_wakeup_ack) w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge wic_clk) begin
        if (pad_cpu_rst) begin
            r_pending    <= '0;
            r_int_prev   <= '0;
            r_cnt        <= '0;
            r_state      <= ST_RUN;
            r_wakeup_req <= 1'b0;
        end else begin
            r_pending    <= w_pend_nxt;
            r_int_prev   <= w_int_src;
            r_cnt        <= w_cnt_nxt;
            r_state      <= w_state_nxt;
            r_wakeup_req <= (w_state_nxt == ST_WAKE);
        end
    end

    assign int_pending = r_pending;
    assign intraw_vld  = |w_enabled;
    assign arb_vld     = w_arb_vld;
    assign arb_id      = w_arb_id;
    assign wakeup_req  = r_wakeup_req;
    assign wic_state   = r_state;

endmodule

// File: tb/tb_wic_ctrl_param.sv
// Self-checking bench for wic_ctrl_param: a 32-source/WAKE_DLY=4 instance and a 64-source/WAKE_DLY=0 instance.
module tb_wic_ctrl_param;
`ifdef WIC_INT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_ARMED = 2'b01;
    localparam logic [1:0] S_DELAY = 2'b10;
    localparam logic [1:0] S_WAKE  = 2'b11;

    logic        wic_clk = 1'b0;
    logic        rst;
    logic [31:0] a_int, a_cfg, a_awk, a_pend;
    logic        a_ack_vld, a_sleep, a_wack, a_intraw, a_arb_vld, a_wreq;
    logic [4:0]  a_ack_id, a_arb_id;
    logic [1:0]  a_state;
    logic [63:0] b_int, b_cfg, b_awk, b_pend;
    logic        b_ack_vld, b_sleep, b_wack, b_intraw, b_arb_vld, b_wreq;
    logic [5:0]  b_ack_id, b_arb_id;
    logic [1:0]  b_state;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] sb_q[$];
    logic [31:0] m_pend, m_prev;
`ifdef WIC_INT_SYNC_EN
    logic [31:0] m_s1, m_s2;
`endif

    always #5 wic_clk = ~wic_clk;

    wic_ctrl_param #(.NUM_INT(32), .ID_W(5), .WAKE_DLY(4), .CNT_W(8)) u_dut (
        .wic_clk(wic_clk), .pad_cpu_rst(rst), .int_vld(a_int), .int_cfg(a_cfg),
        .awake_enable(a_awk), .ack_vld(a_ack_vld), .ack_id(a_ack_id),
        .cpu_sleep_req(a_sleep), .cpu_wakeup_ack(a_wack), .int_pending(a_pend),
        .intraw_vld(a_intraw), .arb_vld(a_arb_vld), .arb_id(a_arb_id),
        .wakeup_req(a_wreq), .wic_state(a_state)
    );

    wic_ctrl_param #(.NUM_INT(64), .ID_W(6), .WAKE_DLY(0), .CNT_W(8)) u_dut64 (
        .wic_clk(wic_clk), .pad_cpu_rst(rst), .int_vld(b_int), .int_cfg(b_cfg),
        .awake_enable(b_awk), .ack_vld(b_ack_vld), .ack_id(b_ack_id),
        .cpu_sleep_req(b_sleep), .cpu_wakeup_ack(b_wack), .int_pending(b_pend),
        .intraw_vld(b_intraw), .arb_vld(b_arb_vld), .arb_id(b_arb_id),
        .wakeup_req(b_wreq), .wic_state(b_state)
    );

    // Advance one clock; predict the 32-source pending vector from the inputs presented this cycle.
    task automatic step();
        logic [31:0] src, hit;
`ifdef WIC_INT_SYNC_EN
        src = m_s2;
`else
        src = a_int;
`endif
        hit = a_ack_vld ? (32'h1 << a_ack_id) : 32'h0;
        if (rst) begin
            m_pend = '0;
            m_prev = '0;
`ifdef WIC_INT_SYNC_EN
            m_s1 = '0;
            m_s2 = '0;
`endif
        end else begin
            m_pend = (a_cfg & ((src & ~m_prev) | (m_pend & ~hit))) | (~a_cfg & src);
            m_prev = src;
`ifdef WIC_INT_SYNC_EN
            m_s2 = m_s1;
            m_s1 = a_int;
`endif
        end
        sb_q.push_back(m_pend);
        @(posedge wic_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b1; a_int = 32'hFFFF_0F0F; a_cfg = 32'h0000_00FF; a_awk = '1;
        a_sleep = 1'b1; b_int = '1; b_awk = '1; b_sleep = 1'b1;
        repeat (3) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL reset_pend_sb: got %h expected %h", a_pend, e); end
        end
        n_chk++; if (a_pend !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h expected 0", a_pend); end
        n_chk++; if (a_intraw !== 1'b0) begin n_fail++; $display("FAIL reset_intraw: got %b expected 0", a_intraw); end
        n_chk++; if (a_arb_vld !== 1'b0) begin n_fail++; $display("FAIL reset_arb_vld: got %b expected 0", a_arb_vld); end
        n_chk++; if (a_arb_id !== 5'd0) begin n_fail++; $display("FAIL reset_arb_id: got %0d expected 0", a_arb_id); end
        n_chk++; if (a_wreq !== 1'b0) begin n_fail++; $display("FAIL reset_wreq: got %b expected 0", a_wreq); end
        n_chk++; if (a_state !== S_RUN) begin n_fail++; $display("FAIL reset_state: got %b expected %b", a_state, S_RUN); end
        n_chk++; if (b_pend !== 64'h0) begin n_fail++; $display("FAIL reset_pend64: got %h expected 0", b_pend); end
        n_chk++; if (b_state !== S_RUN) begin n_fail++; $display("FAIL reset_state64: got %b expected %b", b_state, S_RUN); end
        rst = 1'b0; a_int = '0; a_cfg = '0; a_sleep = 1'b0; b_int = '0; b_sleep = 1'b0;
        repeat (LAT + 1) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL post_reset_pend: got %h expected %h", a_pend, e); end
        end
    endtask

    task automatic test_level();
        logic [31:0] e;
        a_cfg = '0; a_awk = 32'hFFFF_FFFF; a_int = 32'h0000_0100;
        repeat (LAT) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL level_pend_sb: got %h expected %h", a_pend, e); end
        end
        n_chk++; if (a_pend !== 32'h100) begin n_fail++; $display("FAIL level_pend: got %h expected 100", a_pend); end
        n_chk++; if (a_intraw !== 1'b1) begin n_fail++; $display("FAIL level_intraw: got %b expected 1", a_intraw); end
        n_chk++; if (a_arb_id !== 5'd8) begin n_fail++; $display("FAIL level_arb_id: got %0d expected 8", a_arb_id); end
        a_int = '0;
        repeat (LAT) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL level_fall_sb: got %h expected %h", a_pend, e); end
        end
        n_chk++; if (a_pend !== 32'h0) begin n_fail++; $display("FAIL level_fall: got %h expected 0", a_pend); end
    endtask

    task automatic test_pulse();
        logic [31:0] e;
        a_cfg = 32'h0000_0008; a_int = 32'h8;
        step(); e = sb_q.pop_front(); n_chk++;
        if (a_pend !== e) begin n_fail++; $display("FAIL pulse_sb: got %h expected %h", a_pend, e); end
        a_int = '0;
        repeat (LAT - 1) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL pulse_sb: got %h expected %h", a_pend, e); end
        end
        n_chk++; if (a_pend[3] !== 1'b1) begin n_fail++; $display("FAIL pulse_set: got %b expected 1", a_pend[3]); end
        a_ack_vld = 1'b1; a_ack_id = 5'd4;
        step(); e = sb_q.pop_front(); n_chk++;
        if (a_pend !== e) begin n_fail++; $display("FAIL pulse_sb: got %h expected %h", a_pend, e); end
        n_chk++; if (a_pend[3] !== 1'b1) begin n_fail++; $display("FAIL pulse_other_ack: got %b expected 1", a_pend[3]); end
        a_ack_id = 5'd3;
        step(); e = sb_q.pop_front(); n_chk++;
        if (a_pend !== e) begin n_fail++; $display("FAIL pulse_sb: got %h expected %h", a_pend, e); end
        a_ack_vld = 1'b0;
        n_chk++; if (a_pend[3] !== 1'b0) begin n_fail++; $display("FAIL pulse_ack: got %b expected 0", a_pend[3]); end
        // Held-high input: one set, and no re-set after the acknowledge.
        a_int = 32'h8;
        repeat (LAT) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL held_sb: got %h expected %h", a_pend, e); end
        end
        n_chk++; if (a_pend[3] !== 1'b1) begin n_fail++; $display("FAIL held_set: got %b expected 1", a_pend[3]); end
        a_ack_vld = 1'b1;
        repeat (3) begin
            step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL held_sb: got %h expected %h", a_pend, e); end
            a_ack_vld = 1'b0;
        end
        n_chk++; if (a_pend[3] !== 1'b0) begin n_fail++; $display("FAIL held_no_reset: got %b expected 0", a_pend[3]); end
        // Re-arm the bit, then land a new edge and an acknowledge on the same cycle.
        a_int = '0;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end end
        a_int = 32'h8;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end end
        a_int = '0;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end end
        a_int = 32'h8;
        repeat (LAT - 1) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end end
        a_ack_vld = 1'b1; a_ack_id = 5'd3;
        step(); e = sb_q.pop_front(); n_chk++;
        if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end
        n_chk++; if (a_pend[3] !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b expected 1", a_pend[3]); end
        step(); e = sb_q.pop_front(); n_chk++;
        if (a_pend !== e) begin n_fail++; $display("FAIL sim_sb: got %h expected %h", a_pend, e); end
        a_ack_vld = 1'b0;
        n_chk++; if (a_pend[3] !== 1'b0) begin n_fail++; $display("FAIL final_clear: got %b expected 0", a_pend[3]); end
        a_int = '0; a_cfg = '0;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL pulse_tail_sb: got %h expected %h", a_pend, e); end end
    endtask

    task automatic test_arb();
        logic [31:0] e;
        logic        e_vld;
        logic [4:0]  e_id;
        a_cfg = '0; a_int = 32'h0000_0030; a_awk = 32'h0000_0020;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL arb_sb: got %h expected %h", a_pend, e); end end
        n_chk++; if (a_arb_id !== 5'd5) begin n_fail++; $display("FAIL arb_masked_id: got %0d expected 5", a_arb_id); end
        n_chk++; if (a_intraw !== 1'b1) begin n_fail++; $display("FAIL arb_masked_intraw: got %b expected 1", a_intraw); end
        a_awk = '0; #1;
        n_chk++; if (a_arb_vld !== 1'b0) begin n_fail++; $display("FAIL arb_none_vld: got %b expected 0", a_arb_vld); end
        n_chk++; if (a_arb_id !== 5'd0) begin n_fail++; $display("FAIL arb_none_id: got %0d expected 0", a_arb_id); end
        n_chk++; if (a_intraw !== 1'b0) begin n_fail++; $display("FAIL arb_none_intraw: got %b expected 0", a_intraw); end
        a_awk = 32'h0000_0030; #1;
        n_chk++; if (a_arb_id !== 5'd4) begin n_fail++; $display("FAIL arb_prio: got %0d expected 4", a_arb_id); end
        a_int = 32'h8000_0000; a_awk = '1;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL arb_sb: got %h expected %h", a_pend, e); end end
        n_chk++; if (a_arb_id !== 5'd31) begin n_fail++; $display("FAIL arb_top: got %0d expected 31", a_arb_id); end
        repeat (6) begin
            a_int = $urandom; a_awk = $urandom;
            repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
                if (a_pend !== e) begin n_fail++; $display("FAIL arb_rand_sb: got %h expected %h", a_pend, e); end end
            e_vld = 1'b0; e_id = '0;
            for (int i = 0; i < 32; i++)
                if (!e_vld && e[i] && a_awk[i]) begin e_vld = 1'b1; e_id = 5'(i); end
            n_chk++;
            if (a_arb_vld !== e_vld || a_arb_id !== e_id || a_intraw !== e_vld) begin
                n_fail++; $display("FAIL arb_rand: got vld %b id %0d expected vld %b id %0d", a_arb_vld, a_arb_id, e_vld, e_id);
            end
        end
        a_int = '0; a_awk = '1;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL arb_tail_sb: got %h expected %h", a_pend, e); end end
    endtask

    task automatic test_wake_delay();
        logic [31:0] e;
        n_chk++; if (a_state !== S_RUN) begin n_fail++; $display("FAIL wake_start: got %b expected %b", a_state, S_RUN); end
        a_wack = 1'b1;
        step(); e = sb_q.pop_front(); a_wack = 1'b0;
        n_chk++; if (a_state !== S_RUN) begin n_fail++; $display("FAIL wack_in_run: got %b expected %b", a_state, S_RUN); end
        a_sleep = 1'b1;
        step(); e = sb_q.pop_front(); a_sleep = 1'b0;
        n_chk++; if (a_state !== S_ARMED) begin n_fail++; $display("FAIL sleep_armed: got %b expected %b", a_state, S_ARMED); end
        a_int = 32'h2;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL wake_sb: got %h expected %h", a_pend, e); end end
        n_chk++; if (a_state !== S_ARMED || a_intraw !== 1'b1) begin n_fail++;
            $display("FAIL wake_armed_int: got state %b intraw %b expected %b 1", a_state, a_intraw, S_ARMED); end
        for (int k = 0; k < 4; k++) begin
            step(); e = sb_q.pop_front();
            if (k == 1) a_int = '0;
            n_chk++; if (a_state !== S_DELAY || a_wreq !== 1'b0) begin n_fail++;
                $display("FAIL wake_delay%0d: got state %b wreq %b expected %b 0", k, a_state, a_wreq, S_DELAY); end
        end
        step(); e = sb_q.pop_front();
        n_chk++; if (a_state !== S_WAKE || a_wreq !== 1'b1) begin n_fail++;
            $display("FAIL wake_enter: got state %b wreq %b expected %b 1", a_state, a_wreq, S_WAKE); end
        repeat (2) begin step(); e = sb_q.pop_front(); end
        n_chk++; if (a_state !== S_WAKE || a_wreq !== 1'b1) begin n_fail++;
            $display("FAIL wake_hold: got state %b wreq %b expected %b 1", a_state, a_wreq, S_WAKE); end
        a_wack = 1'b1;
        step(); e = sb_q.pop_front(); a_wack = 1'b0;
        n_chk++; if (a_state !== S_RUN || a_wreq !== 1'b0) begin n_fail++;
            $display("FAIL wake_ack: got state %b wreq %b expected %b 0", a_state, a_wreq, S_RUN); end
    endtask

    task automatic test_sleep_pending();
        logic [31:0] e;
        a_int = 32'h1;
        repeat (LAT) begin step(); e = sb_q.pop_front(); n_chk++;
            if (a_pend !== e) begin n_fail++; $display("FAIL slp_sb: got %h expected %h", a_pend, e); end end
        n_chk++; if (a_state !== S_RUN || a_intraw !== 1'b1) begin n_fail++;
            $display("FAIL slp_run: got state %b intraw %b expected %b 1", a_state, a_intraw, S_RUN); end
        a_sleep = 1'b1;
        step(); e = sb_q.pop_front(); a_sleep = 1'b0;
        n_chk++; if (a_state !== S_ARMED) begin n_fail++; $display("FAIL slp_armed: got %b expected %b", a_state, S_ARMED); end
        step(); e = sb_q.pop_front();
        n_chk++; if (a_state !== S_DELAY) begin n_fail++; $display("FAIL slp_delay: got %b expected %b", a_state, S_DELAY); end
        rst = 1'b1; a_int = '0;
        step(); e = sb_q.pop_front(); rst = 1'b0;
        n_chk++; if (a_state !== S_RUN || a_wreq !== 1'b0 || a_pend !== 32'h0) begin n_fail++;
            $display("FAIL slp_reset: got state %b wreq %b pend %h expected %b 0 0", a_state, a_wreq, a_pend, S_RUN); end
    endtask

    task automatic test_wake_nodelay64();
        logic [31:0] e;
        b_cfg = '0; b_awk = '1; b_int = '0;
        b_sleep = 1'b1;
        step(); e = sb_q.pop_front(); b_sleep = 1'b0;
        n_chk++; if (b_state !== S_ARMED) begin n_fail++; $display("FAIL w64_armed: got %b expected %b", b_state, S_ARMED); end
        b_int = 64'h8000_0000_0000_0000;
        repeat (LAT) begin step(); e = sb_q.pop_front(); end
        n_chk++; if (b_pend !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL w64_pend: got %h expected 8000000000000000", b_pend); end
        n_chk++; if (b_arb_id !== 6'd63 || b_arb_vld !== 1'b1) begin n_fail++;
            $display("FAIL w64_arb: got id %0d vld %b expected 63 1", b_arb_id, b_arb_vld); end
        n_chk++; if (b_state !== S_ARMED) begin n_fail++; $display("FAIL w64_still_armed: got %b expected %b", b_state, S_ARMED); end
        step(); e = sb_q.pop_front();
        n_chk++; if (b_state !== S_WAKE || b_wreq !== 1'b1) begin n_fail++;
            $display("FAIL w64_wake: got state %b wreq %b expected %b 1", b_state, b_wreq, S_WAKE); end
        rst = 1'b1; b_int = '0;
        step(); e = sb_q.pop_front(); rst = 1'b0;
        n_chk++; if (b_state !== S_RUN || b_wreq !== 1'b0 || b_pend !== 64'h0 || b_arb_id !== 6'd0) begin n_fail++;
            $display("FAIL w64_reset: got state %b wreq %b pend %h id %0d expected %b 0 0 0", b_state, b_wreq, b_pend, b_arb_id, S_RUN); end
    endtask

    initial begin
        rst = 1'b1;
        a_int = '0; a_cfg = '0; a_awk = '0; a_ack_vld = 1'b0; a_ack_id = '0; a_sleep = 1'b0; a_wack = 1'b0;
        b_int = '0; b_cfg = '0; b_awk = '0; b_ack_vld = 1'b0; b_ack_id = '0; b_sleep = 1'b0; b_wack = 1'b0;
        test_reset();
        test_level();
        test_pulse();
        test_arb();
        test_wake_delay();
        test_sleep_pending();
        test_wake_nodelay64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
